// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Control and sequencing unit for a 32-bit single-cycle MIPS-subset
//   datapath. Decodes the current instruction into datapath strobes and
//   issues ALU and branch instructions in one cycle. Loads and stores hold
//   the PC until the data memory raises Ready. The unit also adds a
//   memory-wait timeout, illegal-opcode trapping and a retired-instruction
//   counter.
//
// Parameters
//   MAX_WAIT : cycles of Ready=0 tolerated before a timeout fault (>= 2)
//   CNT_W    : width of the Retired counter
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset
//   instruction in   current instruction word
//   zero        in   ALU zero flag
//   Ready       in   data memory access complete
//   Mem2reg, Memwrite, PCSrc, ALUSrc, Regdst, Regwrite, Sgnzero
//               out  datapath controls (combinational)
//   ALUOP       out  010 add, 110 sub, 000 and, 001 or, 111 slt
//   PcWrite     out  PC load enable
//   Busy        out  high while waiting on data memory
//   Fault       out  sticky fault flag (registered)
//   FaultCode   out  00 none, 01 illegal instruction, 10 memory timeout
//   Retired     out  retired-instruction count, wraps
module datapath_sequencer #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             zero,
    input  logic             Ready,
    output logic             Mem2reg,
    output logic             Memwrite,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic             Regdst,
    output logic             Regwrite,
    output logic             Sgnzero,
    output logic [2:0]       ALUOP,
    output logic             PcWrite,
    output logic             Busy,
    output logic             Fault,
    output logic [1:0]       FaultCode,
    output logic [CNT_W-1:0] Retired
);

    localparam int unsigned WW = $clog2(MAX_WAIT);
    localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_MEMWAIT,
        S_HALT
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;

    // Decoded fields
    logic [5:0] op;
    logic [5:0] fn;
    logic       legal;
    logic       is_lw;
    logic       is_sw;
    logic       is_mem;
    logic       br_eq;
    logic       br_ne;
    logic       d_alusrc;
    logic       d_sgn;
    logic       d_m2r;
    logic       d_rd;
    logic       d_rw;
    logic [2:0] d_aluop;

    assign op     = instruction[31:26];
    assign fn     = instruction[5:0];
    assign is_mem = is_lw | is_sw;

    always_comb begin
        legal    = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        br_eq    = 1'b0;
        br_ne    = 1'b0;
        d_alusrc = 1'b0;
        d_sgn    = 1'b0;
        d_m2r    = 1'b0;
        d_rd     = 1'b0;
        d_rw     = 1'b0;
        d_aluop  = 3'b000;
        case (op)
            6'b000000: begin
                if (instruction == '0) begin
                    // NOP: legal, no register or memory writes
                    legal = 1'b1;
                end else begin
                    case (fn)
                        6'b100000: begin legal = 1'b1; d_aluop = 3'b010; end
                        6'b100010: begin legal = 1'b1; d_aluop = 3'b110; end
                        6'b100100: begin legal = 1'b1; d_aluop = 3'b000; end
                        6'b100101: begin legal = 1'b1; d_aluop = 3'b001; end
                        6'b101010: begin legal = 1'b1; d_aluop = 3'b111; end
                        default:   legal = 1'b0;
                    endcase
                    d_rd = legal;
                    d_rw = legal;
                end
            end
            6'b100011: begin
                legal = 1'b1; is_lw = 1'b1; d_alusrc = 1'b1; d_sgn = 1'b1;
                d_m2r = 1'b1; d_aluop = 3'b010;
            end
            6'b101011: begin
                legal = 1'b1; is_sw = 1'b1; d_alusrc = 1'b1; d_sgn = 1'b1;
                d_aluop = 3'b010;
            end
            6'b000100: begin legal = 1'b1; br_eq = 1'b1; d_sgn = 1'b1; d_aluop = 3'b110; end
            6'b000101: begin legal = 1'b1; br_ne = 1'b1; d_sgn = 1'b1; d_aluop = 3'b110; end
            6'b001000: begin
                legal = 1'b1; d_alusrc = 1'b1; d_sgn = 1'b1; d_rw = 1'b1; d_aluop = 3'b010;
            end
            6'b001010: begin
                legal = 1'b1; d_alusrc = 1'b1; d_sgn = 1'b1; d_rw = 1'b1; d_aluop = 3'b111;
            end
            6'b001100: begin
                legal = 1'b1; d_alusrc = 1'b1; d_rw = 1'b1; d_aluop = 3'b000;
            end
            6'b001101: begin
                legal = 1'b1; d_alusrc = 1'b1; d_rw = 1'b1; d_aluop = 3'b001;
            end
            default: legal = 1'b0;
        endcase
    end

    // Controls are combinational. Asserting reset silences every strobe in
    // the same cycle so a pending store is abandoned before the reset edge.
    logic active;
    logic mem_phase;
    logic timeout;

    assign active    = reset && legal && (state == S_RUN || state == S_MEMWAIT);
    assign mem_phase = (state == S_MEMWAIT) || is_mem;
    assign timeout   = (state == S_MEMWAIT) && (wait_cnt == LAST_WAIT);

    always_comb begin
        Mem2reg  = 1'b0;
        Memwrite = 1'b0;
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        Regdst   = 1'b0;
        Regwrite = 1'b0;
        Sgnzero  = 1'b0;
        ALUOP    = 3'b000;
        PcWrite  = 1'b0;
        Busy     = reset && (state == S_MEMWAIT);
        if (active) begin
            ALUSrc  = d_alusrc;
            Sgnzero = d_sgn;
            ALUOP   = d_aluop;
            Regdst  = d_rd;
            Mem2reg = d_m2r;
            if (mem_phase) begin
                if (Ready) begin
                    // Completion takes priority over a coincident timeout
                    PcWrite  = 1'b1;
                    Regwrite = is_lw;
                    Memwrite = is_sw;
                end else if (!timeout) begin
                    Memwrite = is_sw;
                end
            end else begin
                PcWrite  = 1'b1;
                Regwrite = d_rw;
                PCSrc    = (br_eq & zero) | (br_ne & ~zero);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            Fault     <= 1'b0;
            FaultCode <= 2'b00;
            Retired   <= '0;
        end else begin
            // Retired advances on exactly the edges where the PC loads
            if (PcWrite)
                Retired <= Retired + CNT_W'(1);
            case (state)
                S_IDLE: state <= S_RUN;
                S_RUN: begin
                    if (!legal) begin
                        state     <= S_HALT;
                        Fault     <= 1'b1;
                        FaultCode <= 2'b01;
                    end else if (is_mem && !Ready) begin
                        state    <= S_MEMWAIT;
                        wait_cnt <= WW'(1);
                    end
                end
                S_MEMWAIT: begin
                    if (Ready) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= S_HALT;
                        Fault     <= 1'b1;
                        FaultCode <= 2'b10;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
